// File: rtl/bram_requester_pkg.sv
// Shared types and helpers for the BRAM request-side controller.
// Holds the FSM encoding, byte-mask expansion and depth limits.
package bram_requester_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_MERGE = 1'b1
  } state_t;

  localparam int RESP_DEPTH_MIN = 2;

  function automatic logic [7:0] byte_mask(
    input logic en
  );
    return {8{en}};
  endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Circular response FIFO holding load data for the consumer.
// Pointers wrap at RESP_DEPTH; push and pop may coincide.
module bram_resp_fifo
  import bram_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = RESP_DEPTH_MIN
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(RESP_DEPTH+1)-1:0] count,
  output logic [DATA_WIDTH-1:0]           rdata
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (r_count == CW'(RESP_DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd];

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < RESP_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop)
        r_rd <= nxt(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bram_requester.sv
// Load/store requester for the dual-port data BRAM with response FIFO.
// Optional MEM_BYTE_WRITE_EN enables read-modify-write partial stores.
module bram_requester
  import bram_requester_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_DEPTH = RESP_DEPTH_MIN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    readEnable,
  output logic [ADDR_WIDTH-1:0]   readAddress,
  input  logic [DATA_WIDTH-1:0]   readData,
  output logic                    writeEnable,
  output logic [ADDR_WIDTH-1:0]   writeAddress,
  output logic [DATA_WIDTH-1:0]   writeData
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  state_t        r_state;
  logic          r_in_flight;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_pop;
  logic          w_credit;
  logic          w_idle;
  logic          w_partial;
  logic          w_acc;
  logic          w_ld;
  logic          w_st;
  logic          w_rmw_go;

`ifdef MEM_BYTE_WRITE_EN
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_mask;
  logic [DATA_WIDTH-1:0] w_bm;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_partial = ~&req_byte_en;

  always_comb begin
    w_bm = '0;
    for (int b = 0; b < NB; b++)
      w_bm[b*8 +: 8] = byte_mask(r_mask[b]);
  end

  assign w_merged = (readData & ~w_bm) | (r_wdata & w_bm);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else if (w_rmw_go) begin
      r_addr  <= req_address;
      r_wdata <= req_wdata;
      r_mask  <= req_byte_en;
    end
  end
`else
  logic w_unused_be;

  assign w_unused_be = ^req_byte_en;
  assign w_partial   = 1'b0;
`endif

  assign w_pop  = resp_valid & resp_ready;
  assign w_occ  = {1'b0, w_count}
                + {{CW{1'b0}}, r_in_flight}
                - {{CW{1'b0}}, w_pop};
  assign w_credit = (w_occ < (CW+1)'(RESP_DEPTH));
  assign w_idle   = (r_state == IDLE);

  // Gated by reset so nothing is accepted while reset is held.
  assign req_ready = reset & w_idle &
                     (req_write ? ~(w_partial & r_in_flight)
                                : w_credit);

  assign w_acc    = req_valid & req_ready;
  assign w_ld     = w_acc & ~req_write;
  assign w_st     = w_acc & req_write & ~w_partial;
  assign w_rmw_go = w_acc & req_write & w_partial;

  assign readEnable  = w_ld | w_rmw_go;
  assign readAddress = readEnable ? req_address : '0;

  always_comb begin
    writeEnable  = w_st;
    writeAddress = w_st ? req_address : '0;
    writeData    = w_st ? req_wdata : '0;
`ifdef MEM_BYTE_WRITE_EN
    if (r_state == RMW_MERGE) begin
      writeEnable  = 1'b1;
      writeAddress = r_addr;
      writeData    = w_merged;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_in_flight <= 1'b0;
    end else begin
      r_in_flight <= w_ld;
      unique case (r_state)
        IDLE:      r_state <= w_rmw_go ? RMW_MERGE : IDLE;
        RMW_MERGE: r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  bram_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_in_flight),
    .wdata (readData),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .rdata (resp_rdata)
  );

  assign resp_valid = ~w_empty;

  logic w_unused_full;
  assign w_unused_full = w_full;

endmodule

// File: tb/tb_bram_requester.sv
// Scoreboard bench for bram_requester with a behavioural RAM.
// Honours MEM_BYTE_WRITE_EN the same way as the design build.
module tb_bram_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_address = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byte_en = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        readEnable;
  logic [7:0]  readAddress;
  logic [31:0] readData = '0;
  logic        writeEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;

  bram_requester dut (
    .clock        (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .req_byte_en  (req_byte_en),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .readEnable   (readEnable),
    .readAddress  (readAddress),
    .readData     (readData),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          exact;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rr_mode = 0;
  bit          lat_exact = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (writeEnable) ram[writeAddress] <= writeData;
    if (readEnable) readData <= ram[readAddress];
  end

  always @(negedge clk) begin
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: sample after stimulus settles, before the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: actual %0h required none",
                 resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_rdata, e.data);
        if (e.exact)
          chk("resp_latency", 64'(cyc - e.cyc), 64'd2);
        else
          chk("resp_latency_min", 64'(cyc - e.cyc >= 2), 64'd1);
      end
    end
  end

  function automatic logic [31:0] model_store(input logic [31:0] old,
                                              input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = d;
`ifdef MEM_BYTE_WRITE_EN
    for (int b = 0; b < 4; b++)
      if (!be[b]) r[b*8 +: 8] = old[b*8 +: 8];
`else
    if (be == 4'h0) r = d;
    if (old === 32'hx) r = d;
`endif
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output int waits);
    waits = 0;
    req_valid = 1'b1;
    req_write = w;
    req_address = a;
    req_wdata = d;
    req_byte_en = be;
    #1;
    while (!req_ready) begin
      @(negedge clk);
      #1;
      waits++;
      if (waits > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: actual stalled required accept");
        req_valid = 1'b0;
        return;
      end
    end
    if (w)
      ref_mem[a] = model_store(ref_mem[a], d, be);
    else
      exp_q.push_back('{ref_mem[a], cyc, lat_exact});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    rr_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, "_readEnable"}, 64'(readEnable), 64'd0);
    chk({tag, "_writeEnable"}, 64'(writeEnable), 64'd0);
    chk({tag, "_readAddress"}, 64'(readAddress), 64'd0);
    chk({tag, "_writeAddress"}, 64'(writeAddress), 64'd0);
    chk({tag, "_writeData"}, 64'(writeData), 64'd0);
  endtask

  initial begin
    int w;
    int wt;
    int stalls;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = ram[i];
    end

    // Power-on reset with a load request pending.
    rr_mode = 0;
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_outputs_zero("por");
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Store then load the same word.
    lat_exact = 1'b1;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, wt);
    issue(1'b0, 8'h10, 32'h0, 4'h0, wt);
    drain();

    // Back-to-back loads with the consumer always ready.
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 8'(i), 32'h0, 4'h0, wt);
      stalls += wt;
    end
    chk("b2b_stalls", 64'(stalls), 64'd0);
    drain();

    // Consumer stalled: credits run out for loads, stores still flow.
    lat_exact = 1'b0;
    rr_mode = 2;
    @(negedge clk);
    issue(1'b0, 8'h01, 32'h0, 4'h0, wt);
    issue(1'b0, 8'h02, 32'h0, 4'h0, wt);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_address = 8'h03;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("credit_stall", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    issue(1'b1, 8'h02, 32'hCAFE_F00D, 4'hF, wt);
    chk("store_while_full", 64'(wt), 64'd0);
    rr_mode = 0;
    issue(1'b0, 8'h03, 32'h0, 4'h0, wt);
    issue(1'b0, 8'h02, 32'h0, 4'h0, wt);
    drain();

    // Partial store.
    lat_exact = 1'b1;
    issue(1'b1, 8'h20, 32'h11223344, 4'hF, wt);
    issue(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, wt);
    issue(1'b0, 8'h20, 32'h0, 4'h0, wt);
`ifdef MEM_BYTE_WRITE_EN
    chk("rmw_ready_low", 64'(wt), 64'd1);
`else
    chk("rmw_ready_low", 64'(wt), 64'd0);
`endif
    drain();
    lat_exact = 1'b0;

    // Reset with data in the FIFO and a load in flight.
    rr_mode = 2;
    @(negedge clk);
    issue(1'b0, 8'h05, 32'h0, 4'h0, wt);
    issue(1'b0, 8'h06, 32'h0, 4'h0, wt);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) begin
      #1;
      chk_outputs_zero("midrst");
      @(negedge clk);
    end
    reset = 1'b1;
    rr_mode = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end

    // Randomised mix of loads and stores with random backpressure.
    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 2) == 0) ? 1 : 0;
      issue(1'(w), 8'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
            wt);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
